// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and data memory (slave).
// The master raises a request and the slave completes it with dmem_ready.
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one EX/MEM load or store on the req/ready data bus,
// stalls the pipeline while it is in flight and returns extended load data.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_memRead,
  input  logic                   mem_memWrite,
  input  logic [31:0]            mem_ALUResult,
  input  logic [31:0]            mem_readData2,
  input  logic [2:0]             mem_funct3,
  mem_stage_lsu_if.master        dmem,
  output logic                   stall_o,
  output logic [31:0]            load_data_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      state_s;
  logic        access_s;
  logic        illegal_s;
  logic        stall_s;
  logic        issue_s;
  logic        fault_s;
  logic        complete_s;
  logic        expire_s;

  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [3:0]  be_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offset_r;
  logic [15:0] cnt_r;
  logic [31:0] load_data_r;
  logic        err_r;

  function automatic logic access_illegal(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] off);
    logic load_ok;
    logic store_ok;
    logic align_ok;
    load_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    store_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    case (f3[1:0])
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return (rd & wr) | (rd & ~load_ok) | (wr & ~store_ok) | ~align_ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign access_s  = mem_memRead | mem_memWrite;
  assign illegal_s = access_illegal(mem_memRead, mem_memWrite, mem_funct3, mem_ALUResult[1:0]);

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_s    = state_r;
    stall_s    = 1'b0;
    issue_s    = 1'b0;
    fault_s    = 1'b0;
    complete_s = 1'b0;
    expire_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && !illegal_s) begin
          stall_s = 1'b1;
          issue_s = 1'b1;
          state_s = BUSY;
        end else if (access_s) begin
          fault_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        if (dmem.dmem_ready) begin
          complete_s = 1'b1;
          state_s    = DONE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          expire_s = 1'b1;
          state_s  = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus request, wait counter, load result and fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      be_r        <= 4'd0;
      funct3_r    <= 3'd0;
      offset_r    <= 2'd0;
      cnt_r       <= 16'd0;
      load_data_r <= 32'd0;
      err_r       <= 1'b0;
    end else begin
      err_r <= fault_s | expire_s;
      if (issue_s) begin
        req_r    <= 1'b1;
        we_r     <= mem_memWrite;
        addr_r   <= {mem_ALUResult[31:2], 2'b00};
        funct3_r <= mem_funct3;
        offset_r <= mem_ALUResult[1:0];
        cnt_r    <= 16'd0;
        if (mem_memWrite) begin
          be_r    <= store_be(mem_funct3[1:0], mem_ALUResult[1:0]);
          wdata_r <= store_wdata(mem_funct3[1:0], mem_readData2);
        end else begin
          be_r <= 4'b1111;
        end
      end else if (complete_s || expire_s) begin
        req_r <= 1'b0;
        // Only a load that actually completed updates the result; timeouts leave it alone.
        if (complete_s && !we_r) begin
          load_data_r <= load_extend(funct3_r, offset_r, dmem.dmem_rdata);
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Reset must release the pipeline at once even while EX/MEM still holds an access.
  assign stall_o         = stall_s & ~rst;
  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_be    = be_r;
  assign load_data_o     = load_data_r;
  assign err_o           = err_r;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage load/store unit. It consumes the EX/MEM pipeline-register outputs and runs each load or store on a multi-cycle data-memory bus using a req/ready handshake. It stalls the upstream pipeline until the access completes, then presents the extended load data to the MEM/WB register. It also generates byte enables and lane-replicated write data for stores, and flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles dmem_req may wait for dmem_ready before the access is abandoned (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
mem_memRead  in  1  load request from EX/MEM
mem_memWrite  in  1  store request from EX/MEM
mem_ALUResult  in  32  effective byte address
mem_readData2  in  32  store source data (rs2)
mem_funct3  in  3  access size/sign
dmem_req  out  1  bus request, registered
dmem_we  out  1  1=write, registered
dmem_addr  out  32  word address {addr[31:2],2'b00}, registered
dmem_wdata  out  32  lane-replicated store data, registered
dmem_be  out  4  byte enables, registered
dmem_rdata  in  32  read word, valid when dmem_ready=1
dmem_ready  in  1  completes the current request
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
load_data_o  out  32  extended load result, registered
err_o  out  1  access fault, one-cycle pulse

Behaviour:
- Reset: state=IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, load_data_o=0, err_o=0, timeout counter=0. Reset during an access aborts it immediately and issues nothing further.
- access = mem_memRead | mem_memWrite.
- illegal is asserted for any of these:
  - both read and write asserted;
  - funct3 ∉ {000,001,010,100,101} on a load;
  - funct3 ∉ {000,001,010} on a store;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access & ~illegal: stall_o=1 combinationally. Next cycle go to BUSY with dmem_req=1 and we/addr/wdata/be registered. Counter cleared.
  - access & illegal: no request, stall_o=0, err_o=1 next cycle for exactly one cycle, stay IDLE.
  - Otherwise stall_o=0.
- BUSY:
  - stall_o=1. All dmem_* outputs are held stable.
  - dmem_ready=1: dmem_req drops next cycle and the next state is DONE. For a load, load_data_o captures the extended data on the same edge.
  - dmem_ready=0 and counter==TIMEOUT-1: dmem_req drops, go to DONE, err_o=1 for one cycle (coincident with DONE), load_data_o unchanged.
  - Otherwise the counter increments.
- DONE:
  - stall_o=0 so the pipeline advances. No new request is issued (the EX/MEM contents are still the completed instruction).
  - Unconditionally go to IDLE.
- Minimum latency: access seen in cycle 0, req in cycle 1, ready in cycle 1, DONE in cycle 2. That is 2 stall cycles. Each extra wait cycle of ready adds one stall cycle.
- Load extension, with byte b selected by addr[1:0] and halfword h by addr[1]:
  - 000 sign-extends b;
  - 100 zero-extends b;
  - 001 sign-extends h;
  - 101 zero-extends h;
  - 010 passes the full word.
- Store encoding:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}};
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}};
  - SW: be=1111, wdata=rs2.
  - Loads drive be=1111 and we=0.
- Outside BUSY: dmem_req=0. be, we, addr and wdata keep their last values.
- load_data_o is held until the next completed load. Stores do not modify it.

Test Plan:
- LW at 0x100, ready in the first req cycle, rdata=0xDEADBEEF → stall_o high for 2 cycles; dmem_addr=0x100, be=1111, we=0; load_data_o=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF_0000 → load_data_o=0xFFFFFF80. LBU at the same address → load_data_o=0x00000080. LHU at 0x102 → load_data_o=0x000080FF.
- SB at 0x201, rs2=0x12345678, ready delayed 3 cycles → be=0010, wdata=0x78787878, addr=0x200; req held stable for 4 cycles; stall_o high for 5 cycles.
- SW at 0x202 → err_o pulses once, dmem_req never asserts, stall_o=0. Read and write asserted together → same response.
- TIMEOUT=4, LW with dmem_ready tied low → req high for exactly 4 cycles, then DONE with err_o=1 and load_data_o unchanged.
- rst asserted in the 2nd BUSY cycle → dmem_req=0 and stall_o=0 immediately, all outputs at reset values, no DONE state.
